// File: rtl/pe_in_sequencer.sv
// Feeds one CNN processing element: a weight load into the PE buffers, then NUM_WIN windows of taps.
// Build macro PE_SEQ_PER_LANE_WRB_EN loads a distinct kernel into every lane instead of broadcasting one.
module pe_in_sequencer #(
   parameter int DATA_WID   = 8,
   parameter int MUL_NUM    = 4,
   parameter int ADDR_B     = 4,
   parameter int KERNEL_LEN = 9,
   parameter int WIN_B      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [WIN_B-1:0]            num_win,
   input  logic                        w_valid,
   input  logic [DATA_WID-1:0]         w_data,
   output logic                        w_ready,
   input  logic                        a_valid,
   input  logic [MUL_NUM*DATA_WID-1:0] a_data,
   output logic                        a_ready,
   output logic [1:0]                  pe_state,
   output logic [MUL_NUM*DATA_WID-1:0] pe_a,
   output logic [DATA_WID-1:0]         pe_wrb_data,
   output logic [ADDR_B-1:0]           pe_wrb_addr,
   output logic [MUL_NUM-1:0]          pe_wrb,
   output logic [ADDR_B-1:0]           pe_rdb_addr,
   output logic                        busy,
   output logic                        done
);

   localparam logic [1:0] PE_INVALID = 2'd0;
   localparam logic [1:0] PE_VALID   = 2'd1;
   localparam logic [1:0] PE_CNN_FIN = 2'd2;

   localparam logic [ADDR_B-1:0] LAST_TAP = ADDR_B'(KERNEL_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_W = 2'd1,
      S_STREAM = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [WIN_B-1:0]            num_win_q, num_win_d;
   logic [WIN_B-1:0]            win_q, win_d;
   logic [ADDR_B-1:0]           waddr_q, waddr_d;
   logic [ADDR_B-1:0]           tap_q, tap_d;
   logic                        w_ready_q, w_ready_d;
   logic                        a_ready_q, a_ready_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [1:0]                  pe_state_q, pe_state_d;
   logic [MUL_NUM*DATA_WID-1:0] pe_a_q, pe_a_d;
   logic [DATA_WID-1:0]         pe_wrb_data_q, pe_wrb_data_d;
   logic [ADDR_B-1:0]           pe_wrb_addr_q, pe_wrb_addr_d;
   logic [MUL_NUM-1:0]          pe_wrb_q, pe_wrb_d;
   logic [ADDR_B-1:0]           pe_rdb_addr_q, pe_rdb_addr_d;

   logic                        w_fire;
   logic                        a_fire;
   logic                        last_word;
   logic                        last_win;
   logic [MUL_NUM-1:0]          lane_mask;

   assign w_fire   = w_valid && w_ready_q;
   assign a_fire   = a_valid && a_ready_q;
   assign last_win = (win_q == (num_win_q - WIN_B'(1)));

`ifdef PE_SEQ_PER_LANE_WRB_EN
   localparam int LANE_B = (MUL_NUM > 1) ? $clog2(MUL_NUM) : 1;
   localparam logic [LANE_B-1:0] LAST_LANE = LANE_B'(MUL_NUM - 1);

   logic [LANE_B-1:0] lane_q, lane_d;

   // Words arrive lane-major: the lane advances each time the address wraps.
   assign last_word = (waddr_q == LAST_TAP) && (lane_q == LAST_LANE);
   assign lane_mask = MUL_NUM'(1) << lane_q;
`else
   assign last_word = (waddr_q == LAST_TAP);
   assign lane_mask = {MUL_NUM{1'b1}};
`endif

   // Next-state, counter and packet logic; packet fields hold unless a handshake rewrites them.
   always_comb begin
      state_d       = state_q;
      num_win_d     = num_win_q;
      win_d         = win_q;
      waddr_d       = waddr_q;
      tap_d         = tap_q;
      pe_state_d    = PE_INVALID;
      pe_a_d        = pe_a_q;
      pe_wrb_data_d = pe_wrb_data_q;
      pe_wrb_addr_d = pe_wrb_addr_q;
      pe_wrb_d      = '0;
      pe_rdb_addr_d = pe_rdb_addr_q;
`ifdef PE_SEQ_PER_LANE_WRB_EN
      lane_d        = lane_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_LOAD_W;
               num_win_d = num_win;
               win_d     = '0;
               waddr_d   = '0;
               tap_d     = '0;
`ifdef PE_SEQ_PER_LANE_WRB_EN
               lane_d    = '0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end

         S_LOAD_W: begin
            if (w_fire) begin
               pe_wrb_data_d = w_data;
               pe_wrb_addr_d = waddr_q;
               pe_wrb_d      = lane_mask;
               if (last_word) begin
                  waddr_d = '0;
`ifdef PE_SEQ_PER_LANE_WRB_EN
                  lane_d  = '0;
`endif
                  state_d = (num_win_q == '0) ? S_FIN : S_STREAM;
               end else if (waddr_q == LAST_TAP) begin
                  waddr_d = '0;
`ifdef PE_SEQ_PER_LANE_WRB_EN
                  lane_d  = lane_q + LANE_B'(1);
`endif
               end else begin
                  waddr_d = waddr_q + ADDR_B'(1);
               end
            end else begin
               pe_wrb_d = '0;
            end
         end

         S_STREAM: begin
            if (a_fire) begin
               pe_a_d        = a_data;
               pe_rdb_addr_d = tap_q;
               if (tap_q == LAST_TAP) begin
                  // Window boundary: no gap, the next tap restarts at address 0.
                  pe_state_d = PE_CNN_FIN;
                  tap_d      = '0;
                  win_d      = win_q + WIN_B'(1);
                  if (last_win) begin
                     state_d = S_FIN;
                  end else begin
                     state_d = S_STREAM;
                  end
               end else begin
                  pe_state_d = PE_VALID;
                  tap_d      = tap_q + ADDR_B'(1);
               end
            end else begin
               pe_state_d = PE_INVALID;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Ready/busy follow the upcoming state so the registered copies line up with it.
      w_ready_d = (state_d == S_LOAD_W);
      a_ready_d = (state_d == S_STREAM);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_q == S_FIN);
   end

   // State, counter and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         num_win_q     <= '0;
         win_q         <= '0;
         waddr_q       <= '0;
         tap_q         <= '0;
         w_ready_q     <= 1'b0;
         a_ready_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pe_state_q    <= PE_INVALID;
         pe_a_q        <= '0;
         pe_wrb_data_q <= '0;
         pe_wrb_addr_q <= '0;
         pe_wrb_q      <= '0;
         pe_rdb_addr_q <= '0;
`ifdef PE_SEQ_PER_LANE_WRB_EN
         lane_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         num_win_q     <= num_win_d;
         win_q         <= win_d;
         waddr_q       <= waddr_d;
         tap_q         <= tap_d;
         w_ready_q     <= w_ready_d;
         a_ready_q     <= a_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pe_state_q    <= pe_state_d;
         pe_a_q        <= pe_a_d;
         pe_wrb_data_q <= pe_wrb_data_d;
         pe_wrb_addr_q <= pe_wrb_addr_d;
         pe_wrb_q      <= pe_wrb_d;
         pe_rdb_addr_q <= pe_rdb_addr_d;
`ifdef PE_SEQ_PER_LANE_WRB_EN
         lane_q        <= lane_d;
`endif
      end
   end

   assign w_ready     = w_ready_q;
   assign a_ready     = a_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pe_state    = pe_state_q;
   assign pe_a        = pe_a_q;
   assign pe_wrb_data = pe_wrb_data_q;
   assign pe_wrb_addr = pe_wrb_addr_q;
   assign pe_wrb      = pe_wrb_q;
   assign pe_rdb_addr = pe_rdb_addr_q;

endmodule

// File: tb/tb_pe_in_sequencer.sv
// Randomized bench for pe_in_sequencer: a job-level model predicts every packet from the accepted words and taps.
`timescale 1ns/1ps
module tb_pe_in_sequencer;

   localparam int DW = 8;
   localparam int MN = 4;
   localparam int AB = 4;
   localparam int KL = 9;
   localparam int WB = 16;
`ifdef PE_SEQ_PER_LANE_WRB_EN
   localparam int NWORDS = MN * KL;
`else
   localparam int NWORDS = KL;
`endif
   localparam logic [1:0] ST_INV = 2'd0;
   localparam logic [1:0] ST_VAL = 2'd1;
   localparam logic [1:0] ST_FIN = 2'd2;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [WB-1:0]     num_win;
   logic              w_valid;
   logic [DW-1:0]     w_data;
   logic              w_ready;
   logic              a_valid;
   logic [MN*DW-1:0]  a_data;
   logic              a_ready;
   logic [1:0]        pe_state;
   logic [MN*DW-1:0]  pe_a;
   logic [DW-1:0]     pe_wrb_data;
   logic [AB-1:0]     pe_wrb_addr;
   logic [MN-1:0]     pe_wrb;
   logic [AB-1:0]     pe_rdb_addr;
   logic              busy;
   logic              done;

   pe_in_sequencer #(.DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB), .KERNEL_LEN(KL), .WIN_B(WB)) dut (
      .clk(clk), .reset(reset), .start(start), .num_win(num_win),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .pe_state(pe_state), .pe_a(pe_a), .pe_wrb_data(pe_wrb_data), .pe_wrb_addr(pe_wrb_addr),
      .pe_wrb(pe_wrb), .pe_rdb_addr(pe_rdb_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]       st;
      logic [MN*DW-1:0] a;
      logic [AB-1:0]    rdb;
      logic [MN-1:0]    wrb;
      logic [AB-1:0]    waddr;
      logic [DW-1:0]    wdata;
      logic             wr;
      logic             ar;
      logic             busy;
      logic             done;
   } pkt_t;

   pkt_t obs_q[$];
   pkt_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   timeout;

   // model state that persists between jobs (registered fields hold until rewritten)
   logic [MN*DW-1:0] m_a;
   logic [AB-1:0]    m_rdb;
   logic [AB-1:0]    m_waddr;
   logic [DW-1:0]    m_wdata;

   function automatic pkt_t sample_dut();
      pkt_t p;
      p.st = pe_state; p.a = pe_a; p.rdb = pe_rdb_addr; p.wrb = pe_wrb;
      p.waddr = pe_wrb_addr; p.wdata = pe_wrb_data; p.wr = w_ready; p.ar = a_ready;
      p.busy = busy; p.done = done;
      return p;
   endfunction

   function automatic logic [MN-1:0] lane_mask(input int j);
`ifdef PE_SEQ_PER_LANE_WRB_EN
      lane_mask = MN'(1) << (j / KL);
`else
      lane_mask = (j >= 0) ? {MN{1'b1}} : {MN{1'b0}};
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; num_win = '0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_a = '0; m_rdb = '0; m_waddr = '0; m_wdata = '0;
   endtask

   // Runs one job from IDLE, logging observed and predicted packets each cycle.
   // mode: 0 valid always, 1 random valid, 2 valid low every third cycle.
   task automatic run_job(input int nw, input int wmode, input int amode, input bit extra_start, input int abort_tap);
      int   wcnt = 0, tcnt = 0, fin_c = -1, c;
      bit   started = 1'b0, w_hs, a_hs, ended = 1'b0, aborted = 1'b0;
      logic [1:0]    nx_st = ST_INV;
      logic [MN-1:0] nx_wrb = '0;
      logic [7:0]    tb8;
      pkt_t e;
      obs_q.delete(); exp_q.delete();
      timeout = 1'b0;
      for (c = 0; c < 3000; c++) begin
         @(negedge clk);
         e.st = nx_st; e.a = m_a; e.rdb = m_rdb; e.wrb = nx_wrb; e.waddr = m_waddr; e.wdata = m_wdata;
         e.wr   = started && (wcnt < NWORDS);
         e.ar   = started && (wcnt == NWORDS) && (tcnt < KL * nw);
         e.done = (fin_c >= 0) && (c == fin_c + 2);
         e.busy = started && !((fin_c >= 0) && (c >= fin_c + 2));
         obs_q.push_back(sample_dut());
         exp_q.push_back(e);
         if ((fin_c >= 0) && (c >= fin_c + 3)) begin ended = 1'b1; break; end
         start   = (c == 0) || (extra_start && (c == 3));
         num_win = (c == 0) ? WB'(nw) : WB'($urandom);
         w_valid = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'($urandom_range(0, 1)) : ((c % 3) != 2);
         a_valid = (amode == 0) ? 1'b1 : (amode == 1) ? 1'($urandom_range(0, 1)) : ((c % 3) != 2);
         w_data  = (wmode == 0) ? DW'(wcnt + 1) : DW'($urandom);
         tb8     = 8'(tcnt % KL);
         a_data  = (amode == 1) ? (MN*DW)'($urandom) : {8'h30 + tb8, 8'h20 + tb8, 8'h10 + tb8, tb8};
         w_hs = w_valid && e.wr;
         a_hs = a_valid && e.ar;
         nx_st = ST_INV; nx_wrb = '0;
         if (w_hs) begin
            nx_wrb = lane_mask(wcnt); m_waddr = AB'(wcnt % KL); m_wdata = w_data;
            wcnt++;
            if ((wcnt == NWORDS) && (nw == 0)) fin_c = c;
         end
         if (a_hs) begin
            m_a = a_data; m_rdb = AB'(tcnt % KL);
            nx_st = ((tcnt % KL) == KL - 1) ? ST_FIN : ST_VAL;
            tcnt++;
            if (tcnt == KL * nw) fin_c = c;
         end
         if (c == 0) started = 1'b1;
         if ((abort_tap >= 0) && (tcnt == abort_tap)) begin aborted = 1'b1; break; end
      end
      if (!ended && !aborted) timeout = 1'b1;
      if (!aborted) begin
         start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (pe_state !== ST_INV) begin bad++; $display("FAIL reset_state got=%0d want=%0d", pe_state, ST_INV); end
      total++; if (pe_a !== '0) begin bad++; $display("FAIL reset_a got=%h want=0", pe_a); end
      total++; if ({pe_wrb_data, pe_wrb_addr, pe_wrb, pe_rdb_addr} !== '0) begin bad++; $display("FAIL reset_wrb got=%h want=0", {pe_wrb_data, pe_wrb_addr, pe_wrb, pe_rdb_addr}); end
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
      total++; if ({w_ready, a_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {w_ready, a_ready}); end
   endtask

   task automatic test_weight_load();
      int nwr = 0;
      run_job(1, 0, 0, 1'b0, -1);
      total++; if (timeout) begin bad++; $display("FAIL wload_timeout got=1 want=0"); end
      foreach (obs_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL wload cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
         if (obs_q[i].wrb !== '0) nwr++;
      end
      total++; if (nwr !== NWORDS) begin bad++; $display("FAIL wload_count got=%0d want=%0d", nwr, NWORDS); end
   endtask

   task automatic test_single_window();
      int nval = 0, nfin = 0, fin_i = -1, done_i = -1;
      run_job(1, 0, 0, 1'b0, -1);
      total++; if (timeout) begin bad++; $display("FAIL win1_timeout got=1 want=0"); end
      foreach (obs_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL win1 cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
         if (obs_q[i].st === ST_VAL) nval++;
         if (obs_q[i].st === ST_FIN) begin nfin++; fin_i = i; end
         if (obs_q[i].done === 1'b1) done_i = i;
      end
      total++; if ((nval !== 8) || (nfin !== 1)) begin bad++; $display("FAIL win1_counts got=%0d/%0d want=8/1", nval, nfin); end
      total++; if ((fin_i < 0) || (done_i !== fin_i + 1)) begin bad++; $display("FAIL win1_done_pos got=%0d want=%0d", done_i, fin_i + 1); end
      total++; if ((done_i < 0) || (obs_q[done_i].busy !== 1'b0)) begin bad++; $display("FAIL win1_busy_drop got=1 want=0"); end
   endtask

   task automatic test_bubbles();
      int ntap = 0, nfin8 = 0, nbub = 0;
      bit in_stream = 1'b0;
      run_job(2, 0, 2, 1'b0, -1);
      total++; if (timeout) begin bad++; $display("FAIL bub_timeout got=1 want=0"); end
      foreach (obs_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bub cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
         if (obs_q[i].st !== ST_INV) begin ntap++; in_stream = 1'b1; end
         else if (in_stream && (ntap < 18)) nbub++;
         if ((obs_q[i].st === ST_FIN) && (obs_q[i].rdb === AB'(8))) nfin8++;
      end
      total++; if (ntap !== 18) begin bad++; $display("FAIL bub_taps got=%0d want=18", ntap); end
      total++; if (nfin8 !== 2) begin bad++; $display("FAIL bub_fin got=%0d want=2", nfin8); end
      total++; if (nbub < 1) begin bad++; $display("FAIL bub_stalls got=%0d want>=1", nbub); end
   endtask

   task automatic test_zero_win();
      int nwr = 0, ntap = 0, ndone = 0;
      run_job(0, 1, 1, 1'b1, -1);
      total++; if (timeout) begin bad++; $display("FAIL zero_timeout got=1 want=0"); end
      foreach (obs_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL zero cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
         if (obs_q[i].wrb !== '0) nwr++;
         if (obs_q[i].st !== ST_INV) ntap++;
         if (obs_q[i].done === 1'b1) ndone++;
      end
      total++; if (nwr !== NWORDS) begin bad++; $display("FAIL zero_writes got=%0d want=%0d", nwr, NWORDS); end
      total++; if (ntap !== 0) begin bad++; $display("FAIL zero_taps got=%0d want=0", ntap); end
      total++; if (ndone !== 1) begin bad++; $display("FAIL zero_done got=%0d want=1", ndone); end
   endtask

   task automatic test_reset_mid();
      pkt_t z = '0;
      pkt_t o;
      int ndone = 0;
      run_job(3, 0, 0, 1'b0, 5);
      foreach (obs_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
      end
      @(negedge clk);
      reset = 1'b1; start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
      @(negedge clk);
      o = sample_dut();
      total++; if (o !== z) begin bad++; $display("FAIL rmid_reset got=%h want=%h", o, z); end
      reset = 1'b0;
      m_a = '0; m_rdb = '0; m_waddr = '0; m_wdata = '0;
      run_job(1, 1, 1, 1'b0, -1);
      total++; if (timeout) begin bad++; $display("FAIL rmid_timeout got=1 want=0"); end
      foreach (obs_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_fresh cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
         if (obs_q[i].done === 1'b1) ndone++;
      end
      total++; if (ndone !== 1) begin bad++; $display("FAIL rmid_done got=%0d want=1", ndone); end
   endtask

   task automatic test_random();
      for (int j = 0; j < 4; j++) begin
         run_job($urandom_range(1, 3), 1, 1, 1'($urandom_range(0, 1)), -1);
         total++; if (timeout) begin bad++; $display("FAIL rand_timeout job=%0d got=1 want=0", j); end
         foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand job=%0d cyc=%0d got=%h want=%h", j, i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=expired want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; num_win = '0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
      test_reset();
      test_weight_load();
      test_single_window();
      test_bubbles();
      test_zero_win();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
